// File: rtl/generador_pwm_multicanal.sv
// Multi-channel PWM generator: internal sawtooth/triangle carrier, double-buffered
// period/duty/mode updates, and complementary gate outputs with dead-time insertion.
module generador_pwm_multicanal #(
  parameter int WIDTH    = 10,
  parameter int CHANNELS = 2,
  parameter int DEAD     = 3
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      enable,
  input  logic                      modo,
  input  logic [WIDTH-1:0]          periodo,
  input  logic [CHANNELS*WIDTH-1:0] Corri_Ref,
  input  logic                      carga,
  output logic [WIDTH-1:0]          Frec_Conm,
  output logic [CHANNELS-1:0]       Out_PWM,
  output logic [CHANNELS-1:0]       Out_PWM_H,
  output logic [CHANNELS-1:0]       Out_PWM_L,
  output logic                      fin_periodo,
  output logic                      pendiente
);

  localparam logic [0:0]       MODE_SAW = 1'b0;
  localparam logic [0:0]       MODE_TRI = 1'b1;
  localparam logic [0:0]       DIR_UP   = 1'b0;
  localparam logic [0:0]       DIR_DOWN = 1'b1;
  localparam logic [WIDTH-1:0] P_MAX    = '1;
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
  localparam logic [7:0]       DEAD_CNT = 8'(DEAD);

  logic [WIDTH-1:0]    carrier_reg, carrier_next;
  logic [0:0]          dir_reg, dir_next, mode_reg;
  logic                run_reg, fin_reg, pend_reg;
  logic                wrap, boundary;
  logic [WIDTH-1:0]    per_act_reg, per_sh_reg;
  logic [WIDTH-1:0]    duty_act_reg [CHANNELS];
  logic [WIDTH-1:0]    duty_sh_reg  [CHANNELS];
  logic [WIDTH-1:0]    ref_ch       [CHANNELS];
  logic [7:0]          dt_reg       [CHANNELS];
  logic [CHANNELS-1:0] out_reg, out_next, h_reg, l_reg, dt_done;

  // Carrier sequencing; a boundary is any cycle where the carrier is reloaded with 0
  // while running, including the first cycle after (re-)enable.
  always_comb begin
    wrap         = 1'b0;
    dir_next     = dir_reg;
    carrier_next = carrier_reg + ONE;
    if (mode_reg == MODE_TRI) begin
      if (dir_reg == DIR_UP) begin
        if (carrier_reg >= per_act_reg) begin
          if (per_act_reg <= ONE) begin
            wrap = 1'b1;
          end else begin
            carrier_next = carrier_reg - ONE;
            dir_next     = DIR_DOWN;
          end
        end
      end else begin
        if (carrier_reg <= ONE) wrap = 1'b1;
        else carrier_next = carrier_reg - ONE;
      end
    end else if (carrier_reg >= per_act_reg) begin
      wrap = 1'b1;
    end
    boundary = enable & (~run_reg | wrap);
    if (!enable || boundary) begin
      carrier_next = '0;
      dir_next     = DIR_UP;
    end
  end

  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      ref_ch[i]   = Corri_Ref[i*WIDTH +: WIDTH];
      out_next[i] = enable & run_reg & (duty_act_reg[i] > carrier_reg);
      dt_done[i]  = (dt_reg[i] == DEAD_CNT);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      carrier_reg <= '0;
      dir_reg     <= DIR_UP;
      mode_reg    <= MODE_SAW;
      run_reg     <= 1'b0;
      fin_reg     <= 1'b0;
      pend_reg    <= 1'b0;
      per_act_reg <= P_MAX;
      per_sh_reg  <= P_MAX;
      out_reg     <= '0;
      h_reg       <= '0;
      l_reg       <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        duty_act_reg[i] <= '0;
        duty_sh_reg[i]  <= '0;
        dt_reg[i]       <= '0;
      end
    end else begin
      carrier_reg <= carrier_next;
      dir_reg     <= dir_next;
      run_reg     <= enable;
      fin_reg     <= boundary;
      out_reg     <= out_next;
      if (carga) per_sh_reg <= periodo;
      // A load landing on a boundary bypasses the shadow and never leaves anything pending.
      if (boundary) begin
        pend_reg <= 1'b0;
        if (carga) begin
          per_act_reg <= periodo;
          mode_reg    <= modo;
        end else if (pend_reg) begin
          per_act_reg <= per_sh_reg;
          mode_reg    <= modo;
        end
      end else if (carga) begin
        pend_reg <= 1'b1;
      end
      for (int i = 0; i < CHANNELS; i++) begin
        if (carga) duty_sh_reg[i] <= ref_ch[i];
        if (boundary && carga) duty_act_reg[i] <= ref_ch[i];
        else if (boundary && pend_reg) duty_act_reg[i] <= duty_sh_reg[i];
        if (!enable || (out_next[i] != out_reg[i])) dt_reg[i] <= '0;
        else if (!dt_done[i]) dt_reg[i] <= dt_reg[i] + 8'd1;
        h_reg[i] <= enable & out_reg[i] & dt_done[i];
        l_reg[i] <= enable & ~out_reg[i] & dt_done[i];
      end
    end
  end

  assign Frec_Conm   = carrier_reg;
  assign Out_PWM     = out_reg;
  assign Out_PWM_H   = h_reg;
  assign Out_PWM_L   = l_reg;
  assign fin_periodo = fin_reg;
  assign pendiente   = pend_reg;

endmodule

// File: tb/tb_generador_pwm_multicanal.sv
// Self-checking bench for generador_pwm_multicanal: steady-state vector table, hand-written
// update/enable/reset sequences and randomized traffic against a phase-based reference model.
module tb_generador_pwm_multicanal;
  localparam int W    = 10;
  localparam int CH   = 2;
  localparam int DEAD = 3;

  logic            clk = 1'b0;
  logic            rst_n, enable, modo, carga;
  logic [W-1:0]    periodo;
  logic [CH*W-1:0] Corri_Ref;
  logic [W-1:0]    Frec_Conm;
  logic [CH-1:0]   Out_PWM, Out_PWM_H, Out_PWM_L;
  logic            fin_periodo, pendiente;

  generador_pwm_multicanal #(.WIDTH(W), .CHANNELS(CH), .DEAD(DEAD)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .modo(modo), .periodo(periodo),
    .Corri_Ref(Corri_Ref), .carga(carga), .Frec_Conm(Frec_Conm), .Out_PWM(Out_PWM),
    .Out_PWM_H(Out_PWM_H), .Out_PWM_L(Out_PWM_L), .fin_periodo(fin_periodo),
    .pendiente(pendiente)
  );

  always #5 clk = ~clk;

  int tests  = 0;
  int failed = 0;

  // Reference model: carrier is derived from a phase index within the period.
  bit m_run, m_mode, m_pend, m_fin;
  int m_t, m_p, s_p;
  int m_duty [CH];
  int s_duty [CH];
  bit m_out  [CH];
  bit m_h    [CH];
  bit m_l    [CH];
  bit hist_out [CH][DEAD+1];
  bit hist_en  [DEAD+1];

  function automatic int plen(int p, bit is_tri);
    if (p == 0) return 1;
    return is_tri ? 2*p : p+1;
  endfunction

  function automatic int carrier_of(int t, int p, bit is_tri);
    return (is_tri && t > p) ? 2*p - t : t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    tests++;
    if (act !== exp_v) begin
      failed++;
      $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp_v, $time);
    end
  endtask

  task automatic model_edge();
    bit en, b;
    bit nout [CH];
    int car;
    int refv [CH];
    en = rst_n && enable;
    for (int i = 0; i < CH; i++) refv[i] = int'(Corri_Ref[i*W +: W]);
    if (!rst_n) begin
      m_run = 0; m_t = 0; m_mode = 0; m_pend = 0; m_fin = 0;
      m_p = (1 << W) - 1; s_p = (1 << W) - 1;
      for (int i = 0; i < CH; i++) begin
        m_duty[i] = 0; s_duty[i] = 0; nout[i] = 0; m_h[i] = 0; m_l[i] = 0;
      end
    end else begin
      car = carrier_of(m_t, m_p, m_mode);
      for (int i = 0; i < CH; i++) begin
        nout[i] = en && m_run && (m_duty[i] > car);
        // A gate is on only if the raw output held its level over the last DEAD+1 samples.
        m_h[i] = en;
        m_l[i] = en;
        for (int k = 0; k <= DEAD; k++) begin
          if (!hist_out[i][k]) m_h[i] = 0;
          if (hist_out[i][k])  m_l[i] = 0;
        end
        for (int k = 0; k < DEAD; k++) begin
          if (!hist_en[k]) begin m_h[i] = 0; m_l[i] = 0; end
        end
      end
      b = en && (!m_run || (m_t + 1 >= plen(m_p, m_mode)));
      m_fin = b;
      m_t = (en && !b) ? m_t + 1 : 0;
      if (b) begin
        if (carga) begin
          m_p = int'(periodo); m_mode = modo;
          for (int i = 0; i < CH; i++) m_duty[i] = refv[i];
        end else if (m_pend) begin
          m_p = s_p; m_mode = modo;
          for (int i = 0; i < CH; i++) m_duty[i] = s_duty[i];
        end
        m_pend = 0;
      end else if (carga) begin
        m_pend = 1;
      end
      if (carga) begin
        s_p = int'(periodo);
        for (int i = 0; i < CH; i++) s_duty[i] = refv[i];
      end
      m_run = en;
    end
    for (int i = 0; i < CH; i++) begin
      for (int k = DEAD; k >= 1; k--) hist_out[i][k] = hist_out[i][k-1];
      hist_out[i][0] = nout[i];
      m_out[i] = nout[i];
    end
    for (int k = DEAD; k >= 1; k--) hist_en[k] = hist_en[k-1];
    hist_en[0] = en;
  endtask

  task automatic step();
    logic [CH-1:0] eo, eh, el;
    @(posedge clk);
    model_edge();
    #1;
    for (int i = 0; i < CH; i++) begin
      eo[i] = m_out[i]; eh[i] = m_h[i]; el[i] = m_l[i];
    end
    check("Frec_Conm",   32'(Frec_Conm),   32'(carrier_of(m_t, m_p, m_mode)));
    check("Out_PWM",     32'(Out_PWM),     32'(eo));
    check("Out_PWM_H",   32'(Out_PWM_H),   32'(eh));
    check("Out_PWM_L",   32'(Out_PWM_L),   32'(el));
    check("fin_periodo", 32'(fin_periodo), 32'(m_fin));
    check("pendiente",   32'(pendiente),   32'(m_pend));
  endtask

  task automatic wait_fin(input int limit);
    int n = 0;
    while (fin_periodo !== 1'b1 && n < limit) begin step(); n++; end
    check("wait_fin", 32'(fin_periodo), 32'd1);
  endtask

  task automatic wait_car(input int val, input int limit);
    int n = 0;
    while (Frec_Conm !== W'(val) && n < limit) begin step(); n++; end
    check("wait_carrier", 32'(Frec_Conm), 32'(val));
  endtask

  task automatic load_and_start(input bit md, input int p, input int d0, input int d1);
    enable = 0; carga = 1; modo = md; periodo = W'(p);
    Corri_Ref = {W'(d1), W'(d0)};
    step();
    carga = 0;
    step();
    check("pend_idle", 32'(pendiente), 32'd1);
    enable = 1;
    step();
    check("restart_fin", 32'(fin_periodo), 32'd1);
    check("restart_car", 32'(Frec_Conm), 32'd0);
  endtask

  task automatic count_hi0(input int cycles, output int cnt);
    cnt = 0;
    for (int k = 0; k < cycles; k++) begin
      cnt += int'(Out_PWM[0]);
      step();
    end
  endtask

  typedef struct {
    bit modo;
    int p, d0, d1;
    int period, hi0, hi1, h0, l0, h1, l1;
  } vec_t;

  localparam int NV = 7;
  vec_t vec [NV];

  initial begin
    int hi0, hi1, h0, l0, h1, l1, fins, ovl, cnt;

    vec[0] = '{0,  9, 5,  0, 10,  5,  0,  2,  2,  0, 10};
    vec[1] = '{1, 10, 4, 10, 20,  7, 19,  4, 10, 16,  0};
    vec[2] = '{0,  9, 10, 2, 10, 10,  2, 10,  0,  0,  5};
    vec[3] = '{0,  9, 2,  9, 10,  2,  9,  0,  5,  6,  0};
    vec[4] = '{0,  0, 1,  0,  1,  1,  0,  1,  0,  0,  1};
    vec[5] = '{1,  3, 2,  4,  6,  3,  6,  0,  0,  6,  0};
    vec[6] = '{1,  1, 1,  0,  2,  1,  0,  0,  0,  0,  2};

    rst_n = 0; enable = 0; modo = 0; carga = 0; periodo = '0; Corri_Ref = '0;
    repeat (3) step();
    check("rst_carrier", 32'(Frec_Conm), 32'd0);
    check("rst_out",     32'(Out_PWM),   32'd0);
    check("rst_pend",    32'(pendiente), 32'd0);
    rst_n = 1;

    for (int v = 0; v < NV; v++) begin
      load_and_start(vec[v].modo, vec[v].p, vec[v].d0, vec[v].d1);
      repeat (2*vec[v].period + 8) step();
      wait_fin(4*vec[v].period + 4);
      hi0 = 0; hi1 = 0; h0 = 0; l0 = 0; h1 = 0; l1 = 0; fins = 0; ovl = 0;
      for (int k = 0; k < vec[v].period; k++) begin
        hi0 += int'(Out_PWM[0]);   hi1 += int'(Out_PWM[1]);
        h0  += int'(Out_PWM_H[0]); l0  += int'(Out_PWM_L[0]);
        h1  += int'(Out_PWM_H[1]); l1  += int'(Out_PWM_L[1]);
        fins += int'(fin_periodo);
        if ((Out_PWM_H & Out_PWM_L) != '0) ovl++;
        step();
      end
      check("vec_period_end", 32'(fin_periodo), 32'd1);
      check("vec_fins", 32'(fins), 32'd1);
      check("vec_hi0",  32'(hi0),  32'(vec[v].hi0));
      check("vec_hi1",  32'(hi1),  32'(vec[v].hi1));
      check("vec_h0",   32'(h0),   32'(vec[v].h0));
      check("vec_l0",   32'(l0),   32'(vec[v].l0));
      check("vec_h1",   32'(h1),   32'(vec[v].h1));
      check("vec_l1",   32'(l1),   32'(vec[v].l1));
      check("vec_overlap", 32'(ovl), 32'd0);
      $display("[TB] vec %0d modo=%0d P=%0d d0=%0d d1=%0d: hi0=%0d hi1=%0d h0=%0d l0=%0d h1=%0d l1=%0d",
               v, vec[v].modo, vec[v].p, vec[v].d0, vec[v].d1, hi0, hi1, h0, l0, h1, l1);
    end

    // Buffered update 5 -> 8 requested mid-period.
    load_and_start(0, 9, 5, 0);
    repeat (12) step();
    wait_car(4, 40);
    carga = 1; periodo = W'(9); Corri_Ref = {W'(0), W'(8)};
    step();
    carga = 0;
    check("buf_pend_set", 32'(pendiente), 32'd1);
    cnt = 0;
    for (int k = 0; k < 5; k++) begin
      cnt += int'(Out_PWM[0]);
      check("buf_pend_hold", 32'(pendiente), 32'd1);
      step();
    end
    check("buf_old_duty", 32'(cnt), 32'd1);
    check("buf_pend_clr", 32'(pendiente), 32'd0);
    check("buf_boundary", 32'(fin_periodo), 32'd1);
    count_hi0(10, cnt);
    check("buf_new_duty", 32'(cnt), 32'd8);
    $display("[TB] buffered update: new-period high count %0d", cnt);

    // Load coinciding with a boundary goes straight to active.
    wait_car(9, 20);
    carga = 1; Corri_Ref = {W'(0), W'(3)};
    step();
    carga = 0;
    check("bnd_pend", 32'(pendiente), 32'd0);
    check("bnd_fin",  32'(fin_periodo), 32'd1);
    count_hi0(10, cnt);
    check("bnd_duty", 32'(cnt), 32'd3);
    $display("[TB] load at boundary: high count %0d", cnt);

    // Back-to-back loads: the last one wins.
    wait_car(2, 20);
    carga = 1; Corri_Ref = {W'(0), W'(7)};
    step();
    Corri_Ref = {W'(0), W'(1)};
    step();
    carga = 0;
    check("last_pend", 32'(pendiente), 32'd1);
    wait_fin(20);
    count_hi0(10, cnt);
    check("last_wins", 32'(cnt), 32'd1);
    $display("[TB] last load wins: high count %0d", cnt);

    // Saturated duty, then enable drop and re-enable.
    load_and_start(0, 9, 10, 0);
    repeat (25) step();
    count_hi0(10, cnt);
    check("sat_hi", 32'(cnt), 32'd10);
    check("sat_gate_h", 32'(Out_PWM_H[0]), 32'd1);
    enable = 0;
    step();
    check("dis_carrier", 32'(Frec_Conm), 32'd0);
    check("dis_out", 32'(Out_PWM), 32'd0);
    check("dis_h", 32'(Out_PWM_H), 32'd0);
    check("dis_l", 32'(Out_PWM_L), 32'd0);
    check("dis_fin", 32'(fin_periodo), 32'd0);
    step();
    enable = 1;
    step();
    check("reen_fin", 32'(fin_periodo), 32'd1);
    check("reen_carrier", 32'(Frec_Conm), 32'd0);
    $display("[TB] saturation/enable: high count %0d, restart fin=%0d", cnt, fin_periodo);

    // Reset in the middle of a running period with a load pending.
    repeat (13) step();
    carga = 1; Corri_Ref = {W'(2), W'(4)};
    step();
    carga = 0;
    check("rst2_pend_before", 32'(pendiente), 32'd1);
    rst_n = 0;
    repeat (3) begin
      step();
      check("rst2_carrier", 32'(Frec_Conm), 32'd0);
      check("rst2_out", 32'(Out_PWM), 32'd0);
      check("rst2_h", 32'(Out_PWM_H), 32'd0);
      check("rst2_l", 32'(Out_PWM_L), 32'd0);
      check("rst2_fin", 32'(fin_periodo), 32'd0);
      check("rst2_pend", 32'(pendiente), 32'd0);
    end
    rst_n = 1;
    step();
    $display("[TB] mid-run reset: carrier=%0d pend=%0d", Frec_Conm, pendiente);

    // Randomized traffic against the model.
    for (int n = 0; n < 4000; n++) begin
      rst_n  = ($urandom_range(0, 299) != 0);
      enable = ($urandom_range(0, 39) != 0);
      carga  = ($urandom_range(0, 11) == 0);
      if (carga) begin
        modo = 1'($urandom_range(0, 1));
        periodo = ($urandom_range(0, 7) == 0) ? W'($urandom_range(0, 60)) : W'($urandom_range(0, 12));
        if ($urandom_range(0, 9) == 0) Corri_Ref = {W'($urandom_range(0, 1023)), W'($urandom_range(0, 1023))};
        else Corri_Ref = {W'($urandom_range(0, 14)), W'($urandom_range(0, 14))};
      end else if ($urandom_range(0, 7) == 0) begin
        modo = 1'($urandom_range(0, 1));
      end
      step();
    end
    $display("[TB] random phase: 4000 cycles applied");

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", tests, failed);
    $fatal(1, "watchdog");
  end

endmodule
